// File: rtl/branch_pkg.sv
// Package: branch_pkg
// Shared opcode encodings and result-record sizing for the branch execution unit.
// Opcodes outside BR_BEQ..BR_JALR resolve as "not taken, fall through".
package branch_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] BR_BEQ  = 4'd0;
    localparam logic [OP_W-1:0] BR_BNE  = 4'd1;
    localparam logic [OP_W-1:0] BR_BLT  = 4'd2;
    localparam logic [OP_W-1:0] BR_BGE  = 4'd3;
    localparam logic [OP_W-1:0] BR_BLTU = 4'd4;
    localparam logic [OP_W-1:0] BR_BGEU = 4'd5;
    localparam logic [OP_W-1:0] BR_JAL  = 4'd6;
    localparam logic [OP_W-1:0] BR_JALR = 4'd7;

    // Result record = {tag, taken, addr, link, mispredict}
    localparam int RES_FLAG_W = 2;

    function automatic int res_w(input int addr_w, input int tag_w);
        return tag_w + 2 * addr_w + RES_FLAG_W;
    endfunction

endpackage

// File: rtl/branch_exec_unit_if.sv
// Interface: branch_exec_unit_if
// Issue (RS -> unit) and result (unit -> PC/ROB) handshakes plus flush.
//  slave  : the branch unit (consumes in_*, produces in_ready and res_*)
//  master : the environment (issue side and result consumer)
interface branch_exec_unit_if
    import branch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_rs1;
    logic [DATA_W-1:0] in_rs2;
    logic [DATA_W-1:0] in_imm;
    logic [ADDR_W-1:0] in_pc;
    logic              in_pred_taken;
    logic [ADDR_W-1:0] in_pred_addr;
    logic [TAG_W-1:0]  in_tag;
    logic              res_valid;
    logic              res_ready;
    logic [TAG_W-1:0]  res_tag;
    logic              res_taken;
    logic [ADDR_W-1:0] res_addr;
    logic [ADDR_W-1:0] res_link;
    logic              res_mispredict;

    modport slave (
        input  flush, in_valid, in_op, in_rs1, in_rs2, in_imm, in_pc,
               in_pred_taken, in_pred_addr, in_tag, res_ready,
        output in_ready, res_valid, res_tag, res_taken, res_addr, res_link,
               res_mispredict
    );

    modport master (
        output flush, in_valid, in_op, in_rs1, in_rs2, in_imm, in_pc,
               in_pred_taken, in_pred_addr, in_tag, res_ready,
        input  in_ready, res_valid, res_tag, res_taken, res_addr, res_link,
               res_mispredict
    );
endinterface

// File: rtl/branch_result_fifo.sv
// Module: branch_result_fifo
// Generic DEPTH x W FIFO with synchronous flush and async active-high reset.
// Ports: clk, rst, flush, push/din/full (write side), pop/dout/empty (read side).
// Pointers carry one extra MSB so full and empty are distinguishable.
// Storage is reset so that dout reads 0 straight out of reset.
module branch_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // Push while full is only legal together with a pop; the
            // slot written is the one being read out this cycle.
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/branch_exec_unit.sv
// Module: branch_exec_unit
// Buffered branch execution unit: resolves direction/target of one issued
// branch per cycle, flags mispredicts against the fetch prediction, and
// queues results in branch_result_fifo so a stalled consumer never blocks
// the resolve path.
// Ports: clk, rst (async, active-high), bus (branch_exec_unit_if.slave).
// Optional: BRANCH_PERF_CNT_EN adds perf_branches / perf_mispredicts,
//           32-bit wrapping counters of popped results / popped mispredicts.
module branch_exec_unit
    import branch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    branch_exec_unit_if.slave   bus
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_branches,
    output logic [31:0]         perf_mispredicts
`endif
);
    localparam int RW = res_w(ADDR_W, TAG_W);

    logic              taken;
    logic [ADDR_W-1:0] imm_a;
    logic [ADDR_W-1:0] pc_imm;
    logic [ADDR_W-1:0] pc_4;
    logic [DATA_W-1:0] jalr_sum;
    logic [ADDR_W-1:0] jalr_a;
    logic [ADDR_W-1:0] addr;
    logic              mispredict;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [RW-1:0]     din;
    logic [RW-1:0]     dout;

    // All address arithmetic wraps at ADDR_W bits.
    assign imm_a    = ADDR_W'($signed(bus.in_imm));
    assign pc_imm   = bus.in_pc + imm_a;
    assign pc_4     = bus.in_pc + ADDR_W'(4);
    assign jalr_sum = bus.in_rs1 + bus.in_imm;
    assign jalr_a   = ADDR_W'(jalr_sum);

    always_comb begin
        taken = 1'b0;
        addr  = pc_4;
        case (bus.in_op)
            BR_BEQ:  taken = (bus.in_rs1 == bus.in_rs2);
            BR_BNE:  taken = (bus.in_rs1 != bus.in_rs2);
            BR_BLT:  taken = ($signed(bus.in_rs1) <  $signed(bus.in_rs2));
            BR_BGE:  taken = ($signed(bus.in_rs1) >= $signed(bus.in_rs2));
            BR_BLTU: taken = (bus.in_rs1 <  bus.in_rs2);
            BR_BGEU: taken = (bus.in_rs1 >= bus.in_rs2);
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
        if (bus.in_op == BR_JALR)
            addr = {jalr_a[ADDR_W-1:1], 1'b0};
        else if (taken)
            addr = pc_imm;
    end

    // Target compare only: a right-direction, wrong-target prediction still flags.
    assign mispredict = (addr != bus.in_pred_addr);

    // Flush wins over both handshakes and keeps the input side open.
    assign pop          = !empty && bus.res_ready && !bus.flush;
    assign bus.in_ready = !full || pop || bus.flush;
    assign push         = bus.in_valid && bus.in_ready && !bus.flush;

    assign din = {bus.in_tag, taken, addr, pc_4, mispredict};

    branch_result_fifo #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.flush),
        .push  (push),
        .din   (din),
        .full  (full),
        .pop   (pop),
        .dout  (dout),
        .empty (empty)
    );

    assign bus.res_valid = !empty;
    assign {bus.res_tag, bus.res_taken, bus.res_addr, bus.res_link, bus.res_mispredict} = dout;

`ifdef BRANCH_PERF_CNT_EN
    // Counted at consumption, not at issue; flush leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (pop) begin
            perf_branches <= perf_branches + 32'd1;
            if (bus.res_mispredict)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif
endmodule
